// File: rtl/fas_pkg.sv
// fas_pkg: shared FAS datapath constants, default FIR taps, saturation helper.
// FIR_ROUND_EN (used by fas_fir_stream) selects round-half-up scaling.
package fas_pkg;

  localparam int COEF_W    = 20;
  localparam int NTAPS_MAX = 64;

  localparam logic [15:0] Q88_ONE  = 16'h0100;
  localparam logic [19:0] COEF_ONE = 20'h10000;

  typedef logic [COEF_W-1:0] coef_t;

  // Low-pass shape over taps 0..31; upper half unused at the default NTAPS.
  localparam coef_t FIR_COEF_DEFAULT [NTAPS_MAX] = '{
    20'hFFC00, 20'hFF800, 20'h00000, 20'h01000,
    20'h02800, 20'h04000, 20'h05800, 20'h06800,
    20'h07400, 20'h07C00, 20'h08000, 20'h07C00,
    20'h07400, 20'h06800, 20'h05800, 20'h04000,
    20'h02800, 20'h01000, 20'h00000, 20'hFF800,
    20'hFFC00, 20'hFFE00, 20'h00100, 20'h00180,
    20'h00200, 20'h00180, 20'h00100, 20'h00080,
    20'h00040, 20'hFFFC0, 20'hFFF80, 20'h00000,
    20'h00000, 20'h00000, 20'h00000, 20'h00000,
    20'h00000, 20'h00000, 20'h00000, 20'h00000,
    20'h00000, 20'h00000, 20'h00000, 20'h00000,
    20'h00000, 20'h00000, 20'h00000, 20'h00000,
    20'h00000, 20'h00000, 20'h00000, 20'h00000,
    20'h00000, 20'h00000, 20'h00000, 20'h00000,
    20'h00000, 20'h00000, 20'h00000, 20'h00000,
    20'h00000, 20'h00000, 20'h00000, 20'h00000
  };

  function automatic logic signed [63:0] sat_s(
    input logic signed [63:0] v,
    input int                 ow
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    if (v > hi)
      return hi;
    else if (v < lo)
      return lo;
    else
      return v;
  endfunction

endpackage

// File: rtl/fas_add_tree.sv
// fas_add_tree: combinational binary adder tree with a single output register.
// Inputs are zero-padded up to the next power of two.
module fas_add_tree #(
  parameter int N = 4,
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic signed [W-1:0] in_data [N],
  output logic                out_valid,
  output logic signed [W-1:0] out_sum
);

  localparam int L = $clog2(N);
  localparam int P = 1 << L;

  logic signed [W-1:0] root;

  for (genvar l = 0; l <= L; l++) begin : g_lvl
    logic signed [W-1:0] s [P >> l];
    if (l == 0) begin : g_leaf
      always_comb begin
        s = '{default: '0};
        for (int i = 0; i < N; i++)
          s[i] = in_data[i];
      end
    end else begin : g_node
      always_comb begin
        for (int i = 0; i < (P >> l); i++)
          s[i] = g_lvl[l-1].s[2*i]
               + g_lvl[l-1].s[2*i+1];
      end
    end
  end

  assign root = g_lvl[L].s[0];

  // Sum only loads on valid so the result holds across bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid)
        out_sum <= root;
    end
  end

endmodule

// File: rtl/fas_fir_stream.sv
// fas_fir_stream: streaming direct-form FIR, run-time coefs, Q8.8 saturated out.
// Define FIR_ROUND_EN for round-half-up scaling; default truncates.
module fas_fir_stream
  import fas_pkg::*;
#(
  parameter int DW    = 16,
  parameter int CW    = 20,
  parameter int CFRAC = 16,
  parameter int NTAPS = 32,
  parameter int OW    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       data_valid,
  input  logic [DW-1:0]              data,
  input  logic                       coef_we,
  input  logic [$clog2(NTAPS)-1:0]   coef_addr,
  input  logic [CW-1:0]              coef_data,
  output logic                       fir_valid,
  output logic [OW-1:0]              fir_d,
  output logic [$clog2(NTAPS+1)-1:0] fill_cnt
);

  localparam int AD = $clog2(NTAPS);
  localparam int FW = $clog2(NTAPS+1);
  localparam int PW = DW + CW;
  localparam int AW = DW + CW + $clog2(NTAPS);

`ifdef FIR_ROUND_EN
  localparam logic signed [AW-1:0] RND =
    AW'(1) <<< (CFRAC - 1);
`else
  localparam logic signed [AW-1:0] RND = '0;
`endif

  logic signed [DW-1:0] x [NTAPS];
  logic signed [CW-1:0] c [NTAPS];
  logic signed [PW-1:0] p [NTAPS];
  logic signed [AW-1:0] tin [NTAPS+1];

  logic [FW-1:0] fill_q;
  logic          full_next;
  logic          acc_v;
  logic          prod_v;

  logic                 wr_v;
  logic [AD-1:0]        wr_addr;
  logic signed [CW-1:0] wr_data;

  logic signed [AW-1:0] sum_q;
  logic signed [AW-1:0] scaled;

  assign full_next = (fill_q >= FW'(NTAPS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x      <= '{default: '0};
      fill_q <= '0;
      acc_v  <= 1'b0;
    end else begin
      acc_v <= data_valid && full_next;
      if (data_valid) begin
        x[0] <= data;
        for (int k = 1; k < NTAPS; k++)
          x[k] <= x[k-1];
        if (fill_q != FW'(NTAPS))
          fill_q <= fill_q + FW'(1);
      end
    end
  end

  // Writes land one edge late so a sample accepted
  // alongside a write still multiplies by the old set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_v    <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      for (int k = 0; k < NTAPS; k++)
        c[k] <= CW'(FIR_COEF_DEFAULT[k]);
    end else begin
      wr_v    <= coef_we;
      wr_addr <= coef_addr;
      wr_data <= coef_data;
      if (wr_v && (32'(wr_addr) < NTAPS))
        c[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_v <= 1'b0;
      p      <= '{default: '0};
    end else begin
      prod_v <= acc_v;
      if (acc_v)
        for (int k = 0; k < NTAPS; k++)
          p[k] <= PW'(x[k]) * PW'(c[k]);
    end
  end

  // The rounding bias rides along as one extra tree leaf.
  always_comb begin
    for (int k = 0; k < NTAPS; k++)
      tin[k] = AW'(p[k]);
    tin[NTAPS] = RND;
  end

  fas_add_tree #(
    .N (NTAPS + 1),
    .W (AW)
  ) u_tree (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (prod_v),
    .in_data   (tin),
    .out_valid (fir_valid),
    .out_sum   (sum_q)
  );

  assign scaled   = sum_q >>> CFRAC;
  assign fir_d    = OW'(sat_s(64'(scaled), OW));
  assign fill_cnt = fill_q;

endmodule

// File: tb/tb_fas_fir_stream.sv
// tb_fas_fir_stream: directed vector bench for the streaming FIR.
// Expected values follow the FIR_ROUND_EN build selection.
`timescale 1ns/1ps
module tb_fas_fir_stream;
  import fas_pkg::*;

  localparam int DW    = 16;
  localparam int CW    = 20;
  localparam int CFRAC = 16;
  localparam int NTAPS = 32;
  localparam int OW    = 16;
  localparam int AD    = $clog2(NTAPS);
  localparam int FW    = $clog2(NTAPS+1);
  localparam int NOBS  = 512;

`ifdef FIR_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          data_valid;
  logic [DW-1:0] data;
  logic          coef_we;
  logic [AD-1:0] coef_addr;
  logic [CW-1:0] coef_data;
  logic          fir_valid;
  logic [OW-1:0] fir_d;
  logic [FW-1:0] fill_cnt;

  always #5 clk = ~clk;

  fas_fir_stream #(
    .DW (DW), .CW (CW), .CFRAC (CFRAC),
    .NTAPS (NTAPS), .OW (OW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_valid (data_valid),
    .data       (data),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .fir_valid  (fir_valid),
    .fir_d      (fir_d),
    .fill_cnt   (fill_cnt)
  );

  typedef struct packed {
    logic [19:0] c0;
    logic [19:0] cr;
    logic [15:0] d;
    logic [15:0] y;
  } vec_t;

  int n_run  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic          ov  [NOBS];
  logic [15:0]   od  [NOBS];
  logic [FW-1:0] ofc [NOBS];
  logic          dvv [NOBS];
  logic [15:0]   dd  [NOBS];

  vec_t vt [11];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic step(input logic dv,
                      input logic [15:0] d,
                      input logic we,
                      input logic [AD-1:0] a,
                      input logic [CW-1:0] cd);
    data_valid = dv;
    data       = d;
    coef_we    = we;
    coef_addr  = a;
    coef_data  = cd;
    @(posedge clk);
    #1;
    if (cyc < NOBS) begin
      ov[cyc]  = fir_valid;
      od[cyc]  = fir_d;
      ofc[cyc] = fill_cnt;
      dvv[cyc] = dv;
      dd[cyc]  = d;
    end
    cyc++;
  endtask

  task automatic idle();
    step(1'b0, 16'h0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    data_valid = 1'b0;
    coef_we    = 1'b0;
    data       = '0;
    coef_addr  = '0;
    coef_data  = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    cyc = 0;
  endtask

  task automatic load_coefs(input logic [19:0] c0,
                            input logic [19:0] cr);
    for (int k = 0; k < NTAPS; k++)
      step(1'b0, 16'h0, 1'b1, AD'(k), (k == 0) ? c0 : cr);
    cyc = 0;
  endtask

  function automatic int first_valid(input int n);
    for (int i = 0; i < n; i++)
      if (ov[i] === 1'b1) return i;
    return -1;
  endfunction

  function automatic int count_valid(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i < hi; i++)
      if (ov[i] === 1'b1) n++;
    return n;
  endfunction

  initial begin
    int fv;
    int cv;
    logic signed [19:0] cs;
    logic [15:0] ey;

    vt[0]  = '{20'h10000, 20'h00000, 16'h0123, 16'h0123};
    vt[1]  = '{20'h10000, 20'h00000, 16'hFE80, 16'hFE80};
    vt[2]  = '{20'hF0000, 20'h00000, 16'h0100, 16'hFF00};
    vt[3]  = '{20'h00800, 20'h00800, 16'h0240, 16'h0240};
    vt[4]  = '{20'hFF800, 20'hFF800, 16'h0300, 16'hFD00};
    vt[5]  = '{20'h7FFFF, 20'h7FFFF, 16'h7FFF, 16'h7FFF};
    vt[6]  = '{20'h7FFFF, 20'h7FFFF, 16'h8000, 16'h8000};
    vt[7]  = '{20'h08000, 20'h00000, 16'h0001,
               RND ? 16'h0001 : 16'h0000};
    vt[8]  = '{20'h08000, 20'h00000, 16'hFFFF,
               RND ? 16'h0000 : 16'hFFFF};
    vt[9]  = '{20'h18000, 20'h00000, 16'h0003,
               RND ? 16'h0005 : 16'h0004};
    vt[10] = '{20'h18000, 20'h00000, 16'hFFFD,
               RND ? 16'hFFFC : 16'hFFFB};

    // Reset state, sampled while rst is still high.
    data_valid = 1'b0;
    coef_we    = 1'b0;
    data       = '0;
    coef_addr  = '0;
    coef_data  = '0;
    rst = 1'b1;
    #12;
    chk("rst_valid", 32'(fir_valid), 32'd0);
    chk("rst_fir_d", 32'(fir_d), 32'd0);
    chk("rst_fill", 32'(fill_cnt), 32'd0);

    // Constant-input vectors: one output after NTAPS samples.
    for (int v = 0; v < 11; v++) begin
      do_reset();
      load_coefs(vt[v].c0, vt[v].cr);
      for (int s = 0; s < NTAPS; s++)
        step(1'b1, vt[v].d, 1'b0, '0, '0);
      idle();
      idle();
      idle();
      fv = first_valid(NTAPS + 3);
      chk($sformatf("vec%0d_fill1", v), 32'(ofc[0]), 32'd1);
      chk($sformatf("vec%0d_first", v), 32'(fv), 32'(NTAPS + 1));
      if (fv >= 0)
        chk($sformatf("vec%0d_y", v), 32'(od[fv]), 32'(vt[v].y));
      chk($sformatf("vec%0d_nvalid", v),
          32'(count_valid(0, NTAPS + 3)), 32'd1);
      chk($sformatf("vec%0d_hold", v),
          32'(od[NTAPS + 2]), 32'(vt[v].y));
      chk($sformatf("vec%0d_fillend", v),
          32'(ofc[NTAPS + 2]), 32'(NTAPS));
    end

    // Identity tracking over a ramp, 2-cycle latency.
    do_reset();
    load_coefs(COEF_ONE, 20'h0);
    for (int s = 0; s < 40; s++)
      step(1'b1, 16'((s + 1) * 16'h0100), 1'b0, '0, '0);
    idle();
    idle();
    for (int s = 0; s < 42; s++) begin
      chk($sformatf("ramp_v%0d", s), 32'(ov[s]),
          32'(s >= NTAPS + 1));
      if (s >= NTAPS + 1)
        chk($sformatf("ramp_d%0d", s), 32'(od[s]),
            32'(16'((s - 1) * 16'h0100)));
    end
    chk("ramp_fill_sat", 32'(ofc[39]), 32'(NTAPS));

    // Impulse through the default coefficient table.
    do_reset();
    for (int s = 0; s < NTAPS - 1; s++)
      step(1'b1, 16'h0, 1'b0, '0, '0);
    step(1'b1, Q88_ONE, 1'b0, '0, '0);
    for (int s = 0; s < NTAPS - 1; s++)
      step(1'b1, 16'h0, 1'b0, '0, '0);
    idle();
    idle();
    chk("imp_early", 32'(count_valid(0, NTAPS + 1)), 32'd0);
    for (int k = 0; k < NTAPS; k++) begin
      cs = FIR_COEF_DEFAULT[k];
      cv = int'(cs) * 256 + (RND ? 32768 : 0);
      ey = 16'(cv >>> 16);
      chk($sformatf("imp_v%0d", k), 32'(ov[NTAPS + 1 + k]), 32'd1);
      chk($sformatf("imp_d%0d", k), 32'(od[NTAPS + 1 + k]), 32'(ey));
    end

    // Bubbles plus a coefficient write alongside a sample.
    do_reset();
    load_coefs(COEF_ONE, 20'h0);
    for (int s = 0; s < 32; s++)
      step(1'b1, 16'(s * 16), 1'b0, '0, '0);
    for (int s = 32; s < 48; s++)
      step((s % 2) == 0, 16'(s * 16), s == 38, '0, 20'h20000);
    idle();
    idle();
    for (int s = 34; s < 50; s++) begin
      chk($sformatf("bub_v%0d", s), 32'(ov[s]), 32'(dvv[s-2]));
      if (dvv[s-2])
        chk($sformatf("bub_d%0d", s), 32'(od[s]),
            32'(16'(dd[s-2] * ((s - 2 > 38) ? 2 : 1))));
      else
        chk($sformatf("bub_hold%0d", s), 32'(od[s]), 32'(od[s-1]));
    end

    // Reset with two results in flight.
    do_reset();
    load_coefs(COEF_ONE, 20'h0);
    for (int s = 0; s < NTAPS + 4; s++)
      step(1'b1, 16'h0400, 1'b0, '0, '0);
    chk("mid_pre_valid", 32'(ov[NTAPS + 3]), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(fir_valid), 32'd0);
    chk("mid_rst_fill", 32'(fill_cnt), 32'd0);
    chk("mid_rst_d", 32'(fir_d), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    for (int s = 0; s < NTAPS; s++)
      step(1'b1, Q88_ONE, 1'b0, '0, '0);
    idle();
    idle();
    idle();
    chk("mid_first", 32'(first_valid(NTAPS + 3)), 32'(NTAPS + 1));
    chk("mid_fill1", 32'(ofc[0]), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
